write_resp_mux: RTL

- Return-path companion to the interconnect's write address decoder.
- Records the target slave and AWID of every accepted AW transfer in an in-order queue.
- Routes each slave's write response (B channel) back to the single master in the same order the AW transfers were issued.
- Flags B responses from slaves with nothing outstanding, and generates DECERR locally for AW transfers that decoded to no slave.

---
 rtl/axi_ic_pkg.sv | 22 ++
 rtl/write_resp_mux_if.sv | 33 +++
 rtl/resp_order_fifo.sv | 60 ++++++
 rtl/write_resp_mux.sv | 123 ++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: response codes, write-response FSM states and
// the in-order queue entry used by the write response mux.
package axi_ic_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Entry fields are sized for the widest slave index / AXI ID the interconnect supports.
  localparam int unsigned AXI_SLV_IDX_W = 8;
  localparam int unsigned AXI_ID_MAX_W  = 16;

  typedef enum logic {
    IDLE,
    RESP
  } wr_resp_state_e;

  typedef struct packed {
    logic [AXI_SLV_IDX_W-1:0] slave;
    logic [AXI_ID_MAX_W-1:0]  id;
  } wr_q_entry_t;

endpackage

// File: rtl/write_resp_mux_if.sv
// AW push notification plus per-slave and master B channels of the write response mux.
interface write_resp_mux_if #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SLV_ID_W   = $clog2(NUM_SLAVES),
  parameter int unsigned ID_W       = 4
);
  logic                              aw_push_valid;
  logic [SLV_ID_W-1:0]               aw_push_slave;
  logic [ID_W-1:0]                   aw_push_id;
  logic                              aw_push_ready;
  logic [NUM_SLAVES-1:0][ID_W-1:0]   slave_bid;
  logic [NUM_SLAVES-1:0][1:0]        slave_bresp;
  logic [NUM_SLAVES-1:0]             slave_bvalid;
  logic [NUM_SLAVES-1:0]             slave_bready;
  logic [ID_W-1:0]                   Master_AXI_bid;
  logic [1:0]                        Master_AXI_bresp;
  logic                              Master_AXI_bvalid;
  logic                              Master_AXI_bready;

  modport master (
    output aw_push_valid, aw_push_slave, aw_push_id,
    output slave_bid, slave_bresp, slave_bvalid, Master_AXI_bready,
    input  aw_push_ready, slave_bready,
    input  Master_AXI_bid, Master_AXI_bresp, Master_AXI_bvalid
  );

  modport slave (
    input  aw_push_valid, aw_push_slave, aw_push_id,
    input  slave_bid, slave_bresp, slave_bvalid, Master_AXI_bready,
    output aw_push_ready, slave_bready,
    output Master_AXI_bid, Master_AXI_bresp, Master_AXI_bvalid
  );
endinterface

// File: rtl/resp_order_fifo.sv
// Synchronous FIFO holding the AW issue order; no bypass, so a push reaches the
// head one cycle later. Pushes when full and pops when empty are ignored.
module resp_order_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [DW-1:0]    rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/write_resp_mux.sv
// Routes slave B responses back to the master in AW issue order; answers decode
// misses with a local DECERR and flags B responses from slaves with nothing pending.
import axi_ic_pkg::*;

module write_resp_mux #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SLV_ID_W   = $clog2(NUM_SLAVES),
  parameter int unsigned ID_W       = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  write_resp_mux_if.slave     bus,
  output logic [CNT_W-1:0]    outstanding_cnt,
  output logic                err_unexpected_b
);
  wr_resp_state_e        state_q, state_d;
  wr_q_entry_t           push_entry, head;
  logic                  fifo_full, fifo_empty, push, pop, head_miss, slave_hs;
  logic [NUM_SLAVES-1:0] head_sel, cnt_zero;
  logic [ID_W-1:0]       bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [CNT_W-1:0]      cnt_q [NUM_SLAVES];
  logic [CNT_W-1:0]      cnt_d [NUM_SLAVES];
  logic                  err_q, err_d;

  assign bus.aw_push_ready = !fifo_full;
  assign push              = bus.aw_push_valid && !fifo_full;
  assign pop               = (state_q == RESP) && bus.Master_AXI_bready;
  assign push_entry        = '{slave: AXI_SLV_IDX_W'(bus.aw_push_slave),
                               id:    AXI_ID_MAX_W'(bus.aw_push_id)};
  assign head_miss         = head.slave >= AXI_SLV_IDX_W'(NUM_SLAVES);
  assign slave_hs          = |(bus.slave_bready & bus.slave_bvalid);

  resp_order_fifo #(
    .DW    ($bits(wr_q_entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_order_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_cnt)
  );

  // One-hot head slave; all zero on a decode miss.
  always_comb begin
    head_sel = '0;
    for (int unsigned j = 0; j < NUM_SLAVES; j++)
      head_sel[j] = (head.slave == AXI_SLV_IDX_W'(j));
  end

  always_comb begin
    state_d = state_q;
    bid_d   = bid_q;
    bresp_d = bresp_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_miss) begin
            state_d = RESP;
            bid_d   = ID_W'(head.id);
            bresp_d = RESP_DECERR;
          end else if (slave_hs) begin
            state_d = RESP;
            for (int unsigned j = 0; j < NUM_SLAVES; j++) begin
              if (head_sel[j]) begin
                bid_d   = bus.slave_bid[j];
                bresp_d = bus.slave_bresp[j];
              end
            end
          end
        end
      end
      RESP: if (bus.Master_AXI_bready) state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.slave_bready = '0;
    if (state_q == IDLE && !fifo_empty) bus.slave_bready = head_sel;
    bus.Master_AXI_bvalid = (state_q == RESP);
    bus.Master_AXI_bid    = bid_q;
    bus.Master_AXI_bresp  = bresp_q;
  end

  always_comb begin
    for (int unsigned j = 0; j < NUM_SLAVES; j++) begin
      cnt_d[j]    = cnt_q[j];
      cnt_zero[j] = (cnt_q[j] == '0);
      case ({push && (bus.aw_push_slave == SLV_ID_W'(j)), pop && head_sel[j]})
        2'b10:   cnt_d[j] = cnt_q[j] + CNT_W'(1);
        2'b01:   cnt_d[j] = cnt_q[j] - CNT_W'(1);
        default: ;
      endcase
    end
    err_d = err_q | (|(bus.slave_bvalid & cnt_zero));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bid_q   <= '0;
      bresp_q <= RESP_OKAY;
      err_q   <= 1'b0;
      for (int unsigned j = 0; j < NUM_SLAVES; j++) cnt_q[j] <= '0;
    end else begin
      state_q <= state_d;
      bid_q   <= bid_d;
      bresp_q <= bresp_d;
      err_q   <= err_d;
      for (int unsigned j = 0; j < NUM_SLAVES; j++) cnt_q[j] <= cnt_d[j];
    end
  end

  assign err_unexpected_b = err_q;
endmodule
